// File: rtl/fp_divide_pkg.sv
// fp_divide_pkg: IEEE-754 single constants, FSM encodings and special-case flags shared by the divider
package fp_divide_pkg;
    localparam int EXP_BIAS = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int Q_BITS = 26;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_NORM = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } flags_t;
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: round-to-nearest-even on a normalized quotient, range clamp and special-case override
module fp_round_pack
    import fp_divide_pkg::*;
#(
    parameter int QBITS = Q_BITS
) (
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [QBITS-1:0]  q,
    input  logic              sticky,
    input  flags_t            flags,
    output logic [31:0]       result
);
    logic              up;
    logic [24:0]       sum;
    logic signed [9:0] e;
    logic [22:0]       frac;
    always_comb begin
        up = q[QBITS-25] & ((|q[QBITS-26:0]) | sticky | q[QBITS-24]);
        sum = {1'b0, q[QBITS-1 -: 24]} + 25'(up);
        e = exp + (sum[24] ? 10'sd1 : 10'sd0);
        frac = sum[24] ? sum[23:1] : sum[22:0];
        result = flags.nan ? QNAN :
                 (flags.inf || e >= 10'sd255) ? {sign, POS_INF[30:0]} :
                 (flags.zero || e <= 10'sd0) ? {sign, 31'h0} :
                 {sign, e[EXP_W-1:0], frac};
    end
endmodule

// File: rtl/fp_divide.sv
// fp_divide: sequential radix-2 restoring IEEE-754 single divider, fixed latency, start/done pulses
module fp_divide
    import fp_divide_pkg::*;
#(
    parameter int QBITS = Q_BITS
) (
    input  logic        fp_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out,
    output logic        done,
    output logic        busy
);
    localparam int LAT = QBITS + 3;
    localparam int CW = $clog2(LAT + 1);
    logic [2:0]        state;
    logic [CW-1:0]     cyc;
    logic [31:0]       a_r, b_r;
    logic              sign;
    logic signed [9:0] exp;
    logic [23:0]       mb;
    logic [24:0]       rem;
    logic [QBITS-1:0]  q;
    flags_t            flags, nf;
    logic              a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf, ge;
    logic [31:0]       result;
    always_comb begin
        a_zero = a_r[30:23] == '0;
        b_zero = b_r[30:23] == '0;
        a_max = &a_r[30:23];
        b_max = &b_r[30:23];
        a_nan = a_max && |a_r[MAN_W-1:0];
        b_nan = b_max && |b_r[MAN_W-1:0];
        a_inf = a_max && !(|a_r[MAN_W-1:0]);
        b_inf = b_max && !(|b_r[MAN_W-1:0]);
        nf.nan = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
        nf.inf = (b_zero & ~a_zero) | (a_inf & ~b_inf);
        nf.zero = a_zero | b_inf;
        ge = rem >= {1'b0, mb};
    end
    fp_round_pack #(.QBITS(QBITS)) u_round (
        .sign   (sign),
        .exp    (exp),
        .q      (q),
        .sticky (|rem),
        .flags  (flags),
        .result (result)
    );
    always_ff @(posedge fp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cyc <= '0;
            a_r <= '0;
            b_r <= '0;
            sign <= 1'b0;
            exp <= '0;
            mb <= '0;
            rem <= '0;
            q <= '0;
            flags <= '0;
            Out <= '0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    // a start coinciding with the done pulse is dropped, not deferred
                    if (start && !done) begin
                        a_r <= A;
                        b_r <= B;
                        busy <= 1'b1;
                        cyc <= CW'(1);
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign <= a_r[31] ^ b_r[31];
                    exp <= {2'b0, a_r[30:23]} - {2'b0, b_r[30:23]} + 10'(EXP_BIAS);
                    mb <= {1'b1, b_r[MAN_W-1:0]};
                    rem <= {2'b01, a_r[MAN_W-1:0]};
                    q <= '0;
                    flags <= nf;
                    cyc <= cyc + 1'b1;
                    state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem <= (ge ? rem - {1'b0, mb} : rem) << 1;
                    q <= {q[QBITS-2:0], ge};
                    cyc <= cyc + 1'b1;
                    if (cyc == CW'(LAT - 2)) state <= S_NORM;
                end
                S_NORM: begin
                    if (!q[QBITS-1]) begin
                        q <= q << 1;
                        exp <= exp - 10'sd1;
                    end
                    cyc <= cyc + 1'b1;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    Out <= result;
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
